// File: rtl/io_pkg.sv
// Shared IO definitions for the memory/IO decoder's output stage.
package io_pkg;

  localparam int unsigned DATA_W     = 16;
  localparam int unsigned SEG_VAL_W  = 32;
  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned NIBBLE_W   = 4;
  localparam int unsigned IDX_W      = 3;
  localparam int unsigned SEG_W      = 8;
  localparam int unsigned GLYPH_W    = 7;

  // IO sub-addresses as presented by the address decoder
  localparam logic [1:0] IOA_NONE   = 2'b00;
  localparam logic [1:0] IOA_SEG_LO = 2'b01;
  localparam logic [1:0] IOA_LED    = 2'b10;
  localparam logic [1:0] IOA_SEG_HI = 2'b11;

  // Full CPU-visible addresses matching the sub-addresses above
  localparam logic [31:0] IO_ADDR_LED    = 32'hFFFF_FC7C;
  localparam logic [31:0] IO_ADDR_SEG_LO = 32'hFFFF_FC80;
  localparam logic [31:0] IO_ADDR_SEG_HI = 32'hFFFF_FC84;

  // All cathodes (or anodes) off on an active-low bus
  localparam logic [SEG_W-1:0] SEG_OFF = 8'hFF;

  typedef enum logic {
    SLOT_BLANK = 1'b0,
    SLOT_SHOW  = 1'b1
  } slot_state_e;

  // Decoded IO write request for one cycle
  typedef struct packed {
    logic              led_we;
    logic              seg_lo_we;
    logic              seg_hi_we;
    logic [DATA_W-1:0] data;
  } io_wr_t;

  // Turn strobes plus sub-address into per-register write enables
  function automatic io_wr_t io_decode(input logic              led_ctrl,
                                       input logic              dig_ctrl,
                                       input logic [1:0]        addr,
                                       input logic [DATA_W-1:0] data);
    io_wr_t wr;
    wr.led_we    = led_ctrl && (addr == IOA_LED);
    wr.seg_lo_we = dig_ctrl && (addr == IOA_SEG_LO);
    wr.seg_hi_we = dig_ctrl && (addr == IOA_SEG_HI);
    wr.data      = data;
    return wr;
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Hex nibble to active-low seven-segment glyph, bit order {g,f,e,d,c,b,a}.
module hex_to_seg7
  import io_pkg::*;
(
  input  logic [NIBBLE_W-1:0] nibble,
  output logic [GLYPH_W-1:0]  seg_c
);

  // Glyph lookup
  always_comb begin
    seg_c = 7'h7F;
    case (nibble)
      4'h0: seg_c = 7'h40;
      4'h1: seg_c = 7'h79;
      4'h2: seg_c = 7'h24;
      4'h3: seg_c = 7'h30;
      4'h4: seg_c = 7'h19;
      4'h5: seg_c = 7'h12;
      4'h6: seg_c = 7'h02;
      4'h7: seg_c = 7'h78;
      4'h8: seg_c = 7'h00;
      4'h9: seg_c = 7'h10;
      4'hA: seg_c = 7'h08;
      4'hB: seg_c = 7'h03;
      4'hC: seg_c = 7'h46;
      4'hD: seg_c = 7'h21;
      4'hE: seg_c = 7'h06;
      4'hF: seg_c = 7'h0E;
      default: seg_c = 7'h7F;
    endcase
  end

endmodule

// File: rtl/io_display_out.sv
// LED register and 8-digit multiplexed hex display driven by IO writes.
module io_display_out
  import io_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 100000,
  parameter int unsigned BLANK_CYC = 16,
  parameter bit          LZ_BLANK  = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        LEDCtrl,
  input  logic        DigitalCtrl,
  input  logic [1:0]  ledaddr,
  input  logic [15:0] led_data,
  output logic [15:0] led,
  output logic [7:0]  seg_an,
  output logic [7:0]  seg_out
);

  localparam int unsigned CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);
  // With no blanking window the very first slot cycle is already lit
  localparam slot_state_e SLOT_RST = (BLANK_CYC == 0) ? SLOT_SHOW : SLOT_BLANK;

  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  slot_state_e          state_q, state_d;
  logic [DATA_W-1:0]    led_q, led_d;
  logic [SEG_VAL_W-1:0] seg_q, seg_d;
  logic [SEG_W-1:0]     seg_an_q, seg_an_d;
  logic [SEG_W-1:0]     seg_out_q, seg_out_d;

  io_wr_t               wr_c;
  logic [NIBBLE_W-1:0]  nibble_c;
  logic [GLYPH_W-1:0]   glyph_c;
  logic [NUM_DIGITS-1:0] lit_c;
  logic                 digit_on_c;

  // IO write decode into the LED and display value registers
  always_comb begin
    wr_c  = io_decode(LEDCtrl, DigitalCtrl, ledaddr, led_data);
    led_d = led_q;
    seg_d = seg_q;
    if (wr_c.led_we)    led_d         = wr_c.data;
    if (wr_c.seg_lo_we) seg_d[15:0]   = wr_c.data;
    if (wr_c.seg_hi_we) seg_d[31:16]  = wr_c.data;
  end

  // A digit stays lit when it or any more significant nibble is non-zero
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_lit
    if (g == 0) begin : g_first
      assign lit_c[g] = 1'b1;
    end else begin : g_upper
      assign lit_c[g] = |seg_q[SEG_VAL_W-1:NIBBLE_W*g];
    end
  end

  assign digit_on_c = !LZ_BLANK || lit_c[idx_q];
  assign nibble_c   = seg_q[{idx_q, 2'b00} +: NIBBLE_W];

  hex_to_seg7 u_hex_to_seg7 (
    .nibble (nibble_c),
    .seg_c  (glyph_c)
  );

  // Scan counter, digit index, slot FSM and registered display drive
  always_comb begin
    cnt_d     = cnt_q + CNT_W'(1);
    idx_d     = idx_q;
    state_d   = state_q;
    seg_an_d  = SEG_OFF;
    seg_out_d = SEG_OFF;

    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      idx_d = idx_q + IDX_W'(1);
    end

    case (state_q)
      SLOT_BLANK: if (cnt_d >= BLANK_END) state_d = SLOT_SHOW;
      SLOT_SHOW:  if (cnt_d <  BLANK_END) state_d = SLOT_BLANK;
      default:    state_d = SLOT_RST;
    endcase

    if (state_q == SLOT_SHOW && digit_on_c) begin
      seg_an_d  = ~(SEG_W'(1) << idx_q);
      seg_out_d = {1'b1, glyph_c};
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      state_q   <= SLOT_RST;
      led_q     <= '0;
      seg_q     <= '0;
      seg_an_q  <= SEG_OFF;
      seg_out_q <= SEG_OFF;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      state_q   <= state_d;
      led_q     <= led_d;
      seg_q     <= seg_d;
      seg_an_q  <= seg_an_d;
      seg_out_q <= seg_out_d;
    end
  end

  assign led     = led_q;
  assign seg_an  = seg_an_q;
  assign seg_out = seg_out_q;

endmodule

// File: tb/tb_io_display_out.sv
// Directed bench for io_display_out: one plain instance and one with leading-zero blanking.
module tb_io_display_out;

  localparam int unsigned SD = 8;
  localparam int unsigned BC = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        LEDCtrl;
  logic        DigitalCtrl;
  logic [1:0]  ledaddr;
  logic [15:0] led_data;
  logic [15:0] led, led_lz;
  logic [7:0]  seg_an, seg_out, seg_an_lz, seg_out_lz;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Expected cathode bytes including dp=1, digits 0..F
  logic [7:0] hex_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  always #5 clk = ~clk;

  io_display_out #(.SCAN_DIV(SD), .BLANK_CYC(BC), .LZ_BLANK(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .LEDCtrl(LEDCtrl), .DigitalCtrl(DigitalCtrl),
    .ledaddr(ledaddr), .led_data(led_data),
    .led(led), .seg_an(seg_an), .seg_out(seg_out)
  );

  io_display_out #(.SCAN_DIV(SD), .BLANK_CYC(BC), .LZ_BLANK(1'b1)) dut_lz (
    .clk(clk), .rst_n(rst_n), .LEDCtrl(LEDCtrl), .DigitalCtrl(DigitalCtrl),
    .ledaddr(ledaddr), .led_data(led_data),
    .led(led_lz), .seg_an(seg_an_lz), .seg_out(seg_out_lz)
  );

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_inputs();
    LEDCtrl     = 1'b0;
    DigitalCtrl = 1'b0;
    ledaddr     = 2'b00;
    led_data    = 16'h0000;
  endtask

  // Expected anodes for the state s edges after reset release, display value v
  function automatic logic [7:0] exp_an(int s, logic [31:0] v, bit lz);
    int c = s % 8;
    int i = (s / 8) % 8;
    if (c < BC) return 8'hFF;
    if (lz && i > 0 && (v >> (4 * i)) == 32'd0) return 8'hFF;
    return ~(8'h01 << i);
  endfunction

  function automatic logic [7:0] exp_out(int s, logic [31:0] v, bit lz);
    int c = s % 8;
    int i = (s / 8) % 8;
    logic [31:0] sh;
    if (c < BC) return 8'hFF;
    if (lz && i > 0 && (v >> (4 * i)) == 32'd0) return 8'hFF;
    sh = (v >> (4 * i)) & 32'hF;
    return hex_tbl[4'(sh)];
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      LEDCtrl     = k[0] ? 1'b0 : 1'b1;
      DigitalCtrl = k[0] ? 1'b1 : 1'b0;
      ledaddr     = k[0] ? 2'b01 : 2'b10;
      led_data    = 16'hBEEF;
      step();
      n_tests++;
      if (led !== 16'h0000 || seg_an !== 8'hFF || seg_out !== 8'hFF ||
          led_lz !== 16'h0000 || seg_an_lz !== 8'hFF || seg_out_lz !== 8'hFF) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: led=%h an=%h out=%h (lz %h %h %h) expected 0000 FF FF",
                 k, led, seg_an, seg_out, led_lz, seg_an_lz, seg_out_lz);
      end
    end
    idle_inputs();
    rst_n = 1'b1;
    cyc   = 0;
    for (int k = 1; k <= 3; k++) begin
      step();
      n_tests++;
      if (k < 3) begin
        if (seg_an !== 8'hFF || seg_out !== 8'hFF || led !== 16'h0000) begin
          n_fail++;
          $display("FAIL reset_release_blank[%0d]: an=%h out=%h led=%h expected FF FF 0000",
                   k, seg_an, seg_out, led);
        end
      end else begin
        if (seg_an !== 8'hFE || seg_out !== 8'hC0 || seg_an_lz !== 8'hFE || seg_out_lz !== 8'hC0) begin
          n_fail++;
          $display("FAIL reset_first_show: an=%h out=%h lz_an=%h lz_out=%h expected FE C0",
                   seg_an, seg_out, seg_an_lz, seg_out_lz);
        end
      end
    end
  endtask

  task automatic test_led_write();
    LEDCtrl = 1'b1; ledaddr = 2'b10; led_data = 16'hA5C3;
    step();
    idle_inputs();
    n_tests++;
    if (led !== 16'hA5C3) begin
      n_fail++;
      $display("FAIL led_write: led=%h expected a5c3", led);
    end
    LEDCtrl = 1'b1; ledaddr = 2'b01; led_data = 16'h1111;
    step();
    n_tests++;
    if (led !== 16'hA5C3) begin
      n_fail++;
      $display("FAIL led_wrong_addr01: led=%h expected a5c3", led);
    end
    ledaddr = 2'b00; led_data = 16'h2222;
    step();
    n_tests++;
    if (led !== 16'hA5C3) begin
      n_fail++;
      $display("FAIL led_wrong_addr00: led=%h expected a5c3", led);
    end
    LEDCtrl = 1'b0; DigitalCtrl = 1'b1; ledaddr = 2'b10; led_data = 16'h3333;
    step();
    idle_inputs();
    n_tests++;
    if (led !== 16'hA5C3) begin
      n_fail++;
      $display("FAIL led_digctrl_addr10: led=%h expected a5c3", led);
    end
  endtask

  task automatic test_display_scan();
    int s;
    DigitalCtrl = 1'b1; ledaddr = 2'b01; led_data = 16'h1234;
    step();
    ledaddr = 2'b11; led_data = 16'hCAFE;
    step();
    idle_inputs();
    step();
    while (cyc % 64 != 0) step();
    for (int k = 0; k < 64; k++) begin
      step();
      s = cyc - 1;
      n_tests++;
      if (seg_an !== exp_an(s, 32'hCAFE_1234, 1'b0) || seg_out !== exp_out(s, 32'hCAFE_1234, 1'b0) ||
          seg_an_lz !== exp_an(s, 32'hCAFE_1234, 1'b1) || seg_out_lz !== exp_out(s, 32'hCAFE_1234, 1'b1)) begin
        n_fail++;
        $display("FAIL scan_cafe1234[s=%0d]: an=%h out=%h lz_an=%h lz_out=%h expected an=%h out=%h",
                 s, seg_an, seg_out, seg_an_lz, seg_out_lz,
                 exp_an(s, 32'hCAFE_1234, 1'b0), exp_out(s, 32'hCAFE_1234, 1'b0));
      end
    end
  endtask

  task automatic test_wrap_midslot();
    int s;
    while (cyc % 64 != 3) step();
    n_tests++;
    if (seg_an !== 8'hFE || seg_out !== 8'h99) begin
      n_fail++;
      $display("FAIL midslot_before: an=%h out=%h expected FE 99", seg_an, seg_out);
    end
    DigitalCtrl = 1'b1; ledaddr = 2'b01; led_data = 16'hFFFF;
    step();
    idle_inputs();
    n_tests++;
    if (seg_an !== 8'hFE || seg_out !== 8'h99) begin
      n_fail++;
      $display("FAIL midslot_write_edge: an=%h out=%h expected FE 99", seg_an, seg_out);
    end
    step();
    n_tests++;
    if (seg_an !== 8'hFE || seg_out !== 8'h8E) begin
      n_fail++;
      $display("FAIL midslot_after: an=%h out=%h expected FE 8E", seg_an, seg_out);
    end
    for (int k = 0; k < 70; k++) begin
      step();
      s = cyc - 1;
      n_tests++;
      if (seg_an !== exp_an(s, 32'hCAFE_FFFF, 1'b0) || seg_out !== exp_out(s, 32'hCAFE_FFFF, 1'b0)) begin
        n_fail++;
        $display("FAIL wrap_scan[s=%0d]: an=%h out=%h expected an=%h out=%h",
                 s, seg_an, seg_out, exp_an(s, 32'hCAFE_FFFF, 1'b0), exp_out(s, 32'hCAFE_FFFF, 1'b0));
      end
    end
  endtask

  task automatic test_lz_blank();
    int s;
    logic [31:0] vals [2] = '{32'h0000_00A0, 32'h0000_0000};
    for (int v = 0; v < 2; v++) begin
      DigitalCtrl = 1'b1; ledaddr = 2'b01; led_data = vals[v][15:0];
      step();
      ledaddr = 2'b11; led_data = vals[v][31:16];
      step();
      idle_inputs();
      step();
      while (cyc % 64 != 0) step();
      for (int k = 0; k < 64; k++) begin
        step();
        s = cyc - 1;
        n_tests++;
        if (seg_an_lz !== exp_an(s, vals[v], 1'b1) || seg_out_lz !== exp_out(s, vals[v], 1'b1) ||
            seg_an !== exp_an(s, vals[v], 1'b0) || seg_out !== exp_out(s, vals[v], 1'b0)) begin
          n_fail++;
          $display("FAIL lz_scan[v=%h s=%0d]: lz_an=%h lz_out=%h an=%h out=%h expected lz %h %h plain %h %h",
                   vals[v], s, seg_an_lz, seg_out_lz, seg_an, seg_out,
                   exp_an(s, vals[v], 1'b1), exp_out(s, vals[v], 1'b1),
                   exp_an(s, vals[v], 1'b0), exp_out(s, vals[v], 1'b0));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int s;
    DigitalCtrl = 1'b1; ledaddr = 2'b01; led_data = 16'h0007;
    step();
    idle_inputs();
    step();
    step();
    rst_n = 1'b0; LEDCtrl = 1'b1; ledaddr = 2'b10; led_data = 16'hFFFF;
    step();
    idle_inputs();
    n_tests++;
    if (led !== 16'h0000 || seg_an !== 8'hFF || seg_out !== 8'hFF) begin
      n_fail++;
      $display("FAIL reset_mid_write: led=%h an=%h out=%h expected 0000 FF FF", led, seg_an, seg_out);
    end
    rst_n = 1'b1;
    cyc   = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      s = cyc - 1;
      n_tests++;
      if (led !== 16'h0000 || seg_an !== exp_an(s, 32'd0, 1'b0) || seg_out !== exp_out(s, 32'd0, 1'b0) ||
          seg_an_lz !== exp_an(s, 32'd0, 1'b1) || seg_out_lz !== exp_out(s, 32'd0, 1'b1)) begin
        n_fail++;
        $display("FAIL reset_restart[s=%0d]: led=%h an=%h out=%h lz_an=%h lz_out=%h expected an=%h out=%h",
                 s, led, seg_an, seg_out, seg_an_lz, seg_out_lz,
                 exp_an(s, 32'd0, 1'b0), exp_out(s, 32'd0, 1'b0));
      end
    end
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    test_reset();
    test_led_write();
    test_display_scan();
    test_wrap_midslot();
    test_lz_blank();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
